// File: rtl/aib_calib_pkg.sv
// Shared definitions for the AIB slave-side calibration controller:
// state codes, CSR indices and CTRL/STATUS bit positions.
package aib_calib_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE              = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_CONF         = 3'd1;
  localparam logic [STATE_W-1:0] ST_ASSERT_READY      = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND_DLL_LOCK_REQ = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_TRANSFER_EN  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE              = 3'd5;
  localparam logic [STATE_W-1:0] ST_ERROR             = 3'd6;

  localparam logic [1:0] CSR_CTRL      = 2'd0;
  localparam logic [1:0] CSR_STATUS    = 2'd1;
  localparam logic [1:0] CSR_CHNL_MASK = 2'd2;
  localparam logic [1:0] CSR_RSVD      = 2'd3;

  localparam int CTRL_CONF_DONE_BIT = 0;
  localparam int CTRL_START_BIT     = 1;
  localparam int CTRL_SOFT_RST_BIT  = 2;

  localparam int STATUS_W = 6;

  typedef struct packed {
    logic                link_lost;
    logic                timeout_err;
    logic                calib_done;
    logic [STATE_W-1:0]  state;
  } status_t;

endpackage

// File: rtl/aib_avmm_csr_slave.sv
// Avalon-MM responder and CSR file: CTRL/STATUS/CHNL_MASK, registered read path,
// start/soft_rst pulses out, status vector in.
module aib_avmm_csr_slave
  import aib_calib_pkg::*;
#(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int AVMM_ADDR_W    = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AVMM_ADDR_W-1:0]    avmm_address_i,
  input  logic                      avmm_read_i,
  input  logic                      avmm_write_i,
  input  logic [31:0]               avmm_writedata_i,
  input  logic [3:0]                avmm_byteenable_i,
  output logic [31:0]               avmm_readdata_o,
  output logic                      avmm_readdatavalid_o,
  output logic                      avmm_waitrequest_o,
  input  logic [STATUS_W-1:0]       status_i,
  output logic                      start_o,
  output logic                      soft_rst_o,
  output logic                      conf_done_o,
  output logic [TOTAL_CHNL_NUM-1:0] mask_o,
  output logic [TOTAL_CHNL_NUM-1:0] mask_nxt_o
);

  logic                      ready_q;
  logic                      rdv_q;
  logic [31:0]               rdata_q, rdata_d;
  logic                      conf_done_q, conf_done_d;
  logic [TOTAL_CHNL_NUM-1:0] mask_q, mask_d;
  logic [1:0]                reg_idx;
  logic                      wr_acc, rd_acc, wr_ctrl_b0;
  logic [31:0]               wmask;
  logic                      unused_ok;

  assign reg_idx    = avmm_address_i[3:2];
  assign wr_acc     = avmm_write_i & ready_q;
  // A simultaneous read+write is treated as a write only.
  assign rd_acc     = avmm_read_i & ~avmm_write_i & ready_q;
  assign wr_ctrl_b0 = wr_acc && (reg_idx == CSR_CTRL) && avmm_byteenable_i[0];
  assign start_o    = wr_ctrl_b0 & avmm_writedata_i[CTRL_START_BIT];
  assign soft_rst_o = wr_ctrl_b0 & avmm_writedata_i[CTRL_SOFT_RST_BIT];
  assign wmask      = {{8{avmm_byteenable_i[3]}}, {8{avmm_byteenable_i[2]}},
                       {8{avmm_byteenable_i[1]}}, {8{avmm_byteenable_i[0]}}};
  assign unused_ok  = ^{avmm_address_i, avmm_writedata_i, wmask};

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    conf_done_d = conf_done_q;
    mask_d      = mask_q;
    if (soft_rst_o)      conf_done_d = 1'b0;
    else if (wr_ctrl_b0) conf_done_d = avmm_writedata_i[CTRL_CONF_DONE_BIT];
    if (wr_acc && (reg_idx == CSR_CHNL_MASK))
      mask_d = (mask_q & ~wmask[TOTAL_CHNL_NUM-1:0]) |
               (avmm_writedata_i[TOTAL_CHNL_NUM-1:0] & wmask[TOTAL_CHNL_NUM-1:0]);
  end

  always_comb begin
    rdata_d = '0;
    unique case (reg_idx)
      CSR_CTRL:      rdata_d[CTRL_CONF_DONE_BIT]   = conf_done_q;
      CSR_STATUS:    rdata_d[STATUS_W-1:0]         = status_i;
      CSR_CHNL_MASK: rdata_d[TOTAL_CHNL_NUM-1:0]   = mask_q;
      default:       rdata_d                       = '0;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
      conf_done_q <= 1'b0;
      mask_q      <= '1;
    end else begin
      ready_q     <= 1'b1;
      rdv_q       <= rd_acc;
      if (rd_acc) rdata_q <= rdata_d;
      conf_done_q <= conf_done_d;
      mask_q      <= mask_d;
    end
  end

  assign avmm_waitrequest_o   = ~ready_q;
  assign avmm_readdatavalid_o = rdv_q;
  assign avmm_readdata_o      = rdata_q;
  assign conf_done_o          = conf_done_q;
  assign mask_o               = mask_q;
  assign mask_nxt_o           = mask_d;

endmodule

// File: rtl/aib_calib_slave_fsm.sv
// Slave-side AIB calibration controller: sequencing FSM, WAIT_TRANSFER_EN timeout,
// and registered channel-output decode from next-state.
module aib_calib_slave_fsm
  import aib_calib_pkg::*;
#(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int TIMEOUT_CYC    = 65535,
  parameter int AVMM_ADDR_W    = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AVMM_ADDR_W-1:0]    avmm_address_i,
  input  logic                      avmm_read_i,
  input  logic                      avmm_write_i,
  input  logic [31:0]               avmm_writedata_i,
  input  logic [3:0]                avmm_byteenable_i,
  output logic [31:0]               avmm_readdata_o,
  output logic                      avmm_readdatavalid_o,
  output logic                      avmm_waitrequest_o,
  output logic [TOTAL_CHNL_NUM-1:0] sl_ns_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] sl_ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_transfer_en,
  output logic                      calib_done,
  output logic                      calib_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [STATE_W-1:0]        state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      link_lost_q, link_lost_d;
  logic                      done_q, err_q;
  logic [TOTAL_CHNL_NUM-1:0] rdy_q, dll_q;
  logic                      start, soft_rst, conf_done, ok, rdy_en, dll_en;
  logic [TOTAL_CHNL_NUM-1:0] mask, mask_nxt;
  status_t                   status;

  assign status = '{link_lost: link_lost_q, timeout_err: timeout_q,
                    calib_done: done_q, state: state_q};

  aib_avmm_csr_slave #(
    .TOTAL_CHNL_NUM (TOTAL_CHNL_NUM),
    .AVMM_ADDR_W    (AVMM_ADDR_W)
  ) u_csr (
    .clk                  (clk),
    .rst_n                (rst_n),
    .avmm_address_i       (avmm_address_i),
    .avmm_read_i          (avmm_read_i),
    .avmm_write_i         (avmm_write_i),
    .avmm_writedata_i     (avmm_writedata_i),
    .avmm_byteenable_i    (avmm_byteenable_i),
    .avmm_readdata_o      (avmm_readdata_o),
    .avmm_readdatavalid_o (avmm_readdatavalid_o),
    .avmm_waitrequest_o   (avmm_waitrequest_o),
    .status_i             (status),
    .start_o              (start),
    .soft_rst_o           (soft_rst),
    .conf_done_o          (conf_done),
    .mask_o               (mask),
    .mask_nxt_o           (mask_nxt)
  );

  // Masked-off channels count as ready.
  assign ok = &((ms_tx_transfer_en & ms_rx_transfer_en) | ~mask);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    timeout_d   = timeout_q;
    link_lost_d = link_lost_q;
    if (soft_rst) begin
      state_d     = ST_IDLE;
      timeout_d   = 1'b0;
      link_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:              if (start) state_d = ST_WAIT_CONF;
        ST_WAIT_CONF:         if (conf_done) state_d = ST_ASSERT_READY;
        ST_ASSERT_READY:      state_d = ST_SEND_DLL_LOCK_REQ;
        ST_SEND_DLL_LOCK_REQ: state_d = ST_WAIT_TRANSFER_EN;
        ST_WAIT_TRANSFER_EN: begin
          if (ok) begin
            state_d = ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!ok) begin
            state_d     = ST_ERROR;
            link_lost_d = 1'b1;
          end
        end
        ST_ERROR:             state_d = ST_ERROR;
        default:              state_d = ST_IDLE;
      endcase
    end
  end

  // Decoding from next-state keeps the outputs aligned with the state register.
  assign rdy_en = state_d inside {ST_ASSERT_READY, ST_SEND_DLL_LOCK_REQ, ST_WAIT_TRANSFER_EN, ST_DONE};
  assign dll_en = state_d inside {ST_SEND_DLL_LOCK_REQ, ST_WAIT_TRANSFER_EN, ST_DONE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      link_lost_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= '0;
      dll_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      link_lost_q <= link_lost_d;
      done_q      <= (state_d == ST_DONE);
      err_q       <= timeout_d | link_lost_d;
      rdy_q       <= rdy_en ? mask_nxt : '0;
      dll_q       <= dll_en ? mask_nxt : '0;
    end
  end

  assign sl_ns_mac_rdy          = rdy_q;
  assign sl_ns_adapter_rstn     = rdy_q;
  assign sl_rx_dcc_dll_lock_req = dll_q;
  assign sl_tx_dcc_dll_lock_req = dll_q;
  assign calib_done             = done_q;
  assign calib_err              = err_q;

endmodule
